// File: rtl/apb_user_reg_responder.sv
// apb_user_reg_responder
// APB completer for the user register interface. Word-aligned accesses are
// decoded into a bank of read/write control registers (offset 0x000) and
// read-only status inputs (offset 0x200). Each committed write to a control
// register raises a one-cycle strobe toward user logic.
//
// Build option: define APB_RSP_WAIT_EN to insert WAIT_CYCLES wait states on
// every transfer. Without it, every transfer completes with zero wait states.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for a setup cycle (psel=1, penable=0)
// S_WAIT | counting wait states (APB_RSP_WAIT_EN only)
// S_RESP | pready high for one cycle; RW write commits on the exit edge

module apb_user_reg_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned NUM_RW      = 8,
    parameter int unsigned NUM_RO      = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                     i_apb_clk,
    input  logic                     i_apb_rst,
    input  logic                     i_apb_psel,
    input  logic                     i_apb_penable,
    input  logic [31:0]              i_apb_paddr,
    input  logic [31:0]              i_apb_pwdata,
    input  logic                     i_apb_pwrite,
    output logic                     o_apb_pready,
    output logic [31:0]              o_apb_prdata,
    output logic                     o_apb_pserr,
    output logic [32*NUM_RW-1:0]     o_rw_reg,
    output logic [NUM_RW-1:0]        o_wr_pulse,
    input  logic [32*NUM_RO-1:0]     i_ro_reg
);

`ifdef APB_RSP_WAIT_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RESP = 2'd2} state_t;
`endif

    state_t                   r_state;
    state_t                   w_state_nxt;

    logic                     r_write;
    logic [31:0]              r_wdata;
    logic [6:0]               r_idx;
    logic                     r_rw_hit;
    logic                     r_ro_hit;

    logic [NUM_RW-1:0][31:0]  r_rw;
    logic [NUM_RW-1:0]        r_wr_pulse;
    logic [31:0]              r_prdata;
    logic                     r_pserr;

    logic                     w_setup;
    logic                     w_base_hit;
    logic [6:0]               w_idx;
    logic                     w_rw_hit;
    logic                     w_ro_hit;

    logic                     w_sel_write;
    logic [6:0]               w_sel_idx;
    logic                     w_sel_rw_hit;
    logic                     w_sel_ro_hit;
    logic                     w_sel_err;
    logic [31:0]              w_rd_data;
    logic                     w_enter_resp;

`ifdef APB_RSP_WAIT_EN
    logic [3:0]               r_wait_cnt;
`else
    logic                     w_unused_bits;
    assign w_unused_bits = ^{i_apb_paddr[1:0], WAIT_CYCLES[3:0]};
`endif

    // live decode of the bus address during the setup cycle
    assign w_setup    = i_apb_psel & ~i_apb_penable;
    assign w_base_hit = (i_apb_paddr[31:12] == BASE_ADDR[31:12]);
    assign w_idx      = i_apb_paddr[8:2];
    assign w_rw_hit   = w_base_hit && (i_apb_paddr[11:9] == 3'b000) && (32'(w_idx) < NUM_RW);
    assign w_ro_hit   = w_base_hit && (i_apb_paddr[11:9] == 3'b001) && (32'(w_idx) < NUM_RO);

    // When RESP is entered straight from IDLE the latched copy is not yet
    // valid, so the response is built from the live decode instead.
    assign w_sel_write  = (r_state == S_IDLE) ? i_apb_pwrite : r_write;
    assign w_sel_idx    = (r_state == S_IDLE) ? w_idx        : r_idx;
    assign w_sel_rw_hit = (r_state == S_IDLE) ? w_rw_hit     : r_rw_hit;
    assign w_sel_ro_hit = (r_state == S_IDLE) ? w_ro_hit     : r_ro_hit;
    assign w_sel_err    = ~(w_sel_rw_hit | w_sel_ro_hit) | (w_sel_write & w_sel_ro_hit);

    assign w_enter_resp = (w_state_nxt == S_RESP) && (r_state != S_RESP);

    // state register
    always_ff @(posedge i_apb_clk) begin
        if (i_apb_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_setup) begin
`ifdef APB_RSP_WAIT_EN
                    w_state_nxt = S_WAIT;
`else
                    w_state_nxt = S_RESP;
`endif
                end
            end
`ifdef APB_RSP_WAIT_EN
            S_WAIT: begin
                if (!i_apb_psel) begin
                    w_state_nxt = S_IDLE;
                end else if (r_wait_cnt == 4'd0) begin
                    w_state_nxt = S_RESP;
                end
            end
`endif
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef APB_RSP_WAIT_EN
    // wait-state down-counter, loaded on the setup cycle
    always_ff @(posedge i_apb_clk) begin
        if (i_apb_rst) begin
            r_wait_cnt <= 4'd0;
        end else if (r_state == S_IDLE && w_setup) begin
            r_wait_cnt <= WAIT_LOAD;
        end else if (r_state == S_WAIT && r_wait_cnt != 4'd0) begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
        end
    end
`endif

    // capture address, direction, data and decode on the setup cycle
    always_ff @(posedge i_apb_clk) begin
        if (i_apb_rst) begin
            r_write  <= 1'b0;
            r_wdata  <= 32'h0;
            r_idx    <= 7'd0;
            r_rw_hit <= 1'b0;
            r_ro_hit <= 1'b0;
        end else if (r_state == S_IDLE && w_setup) begin
            r_write  <= i_apb_pwrite;
            r_wdata  <= i_apb_pwdata;
            r_idx    <= w_idx;
            r_rw_hit <= w_rw_hit;
            r_ro_hit <= w_ro_hit;
        end
    end

    // read-data mux over control registers and status inputs
    always_comb begin
        w_rd_data = 32'h0;
        for (int unsigned i = 0; i < NUM_RW; i++) begin
            if (w_sel_rw_hit && w_sel_idx == 7'(i)) begin
                w_rd_data = r_rw[i];
            end
        end
        for (int unsigned j = 0; j < NUM_RO; j++) begin
            if (w_sel_ro_hit && w_sel_idx == 7'(j)) begin
                w_rd_data = i_ro_reg[32*j +: 32];
            end
        end
    end

    // response data/error, held only for the pready cycle
    always_ff @(posedge i_apb_clk) begin
        if (i_apb_rst) begin
            r_prdata <= 32'h0;
            r_pserr  <= 1'b0;
        end else if (w_enter_resp) begin
            r_prdata <= (w_sel_err || w_sel_write) ? 32'h0 : w_rd_data;
            r_pserr  <= w_sel_err;
        end else begin
            r_prdata <= 32'h0;
            r_pserr  <= 1'b0;
        end
    end

    // control register commit and write strobe on the RESP exit edge
    always_ff @(posedge i_apb_clk) begin
        if (i_apb_rst) begin
            r_rw       <= '0;
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= '0;
            if (r_state == S_RESP && r_write && r_rw_hit) begin
                for (int unsigned i = 0; i < NUM_RW; i++) begin
                    if (r_idx == 7'(i)) begin
                        r_rw[i]       <= r_wdata;
                        r_wr_pulse[i] <= 1'b1;
                    end
                end
            end
        end
    end

    assign o_apb_pready = (r_state == S_RESP);
    assign o_apb_prdata = r_prdata;
    assign o_apb_pserr  = r_pserr;
    assign o_rw_reg     = r_rw;
    assign o_wr_pulse   = r_wr_pulse;

endmodule
